seg_scan_ctrl: RTL

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 16 +
 rtl/seg_scan_ctrl_if.sv | 26 ++
 rtl/seg7_hex_dec.sv | 9 +
 rtl/seg_scan_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller.
package seg_pkg;

    // Hex-to-segment table, active-high, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] HEX7SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
    };

    // Dark patterns in active-high form; output polarity is applied later.
    localparam logic [7:0]  SEG_OFF = 8'h00;
    localparam logic [15:0] AN_OFF  = 16'h0000;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display data in, multiplexed segment/anode drive out.
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8,
    parameter int PWM_BITS   = 4
);
    logic [4*NUM_DIGITS-1:0] digits_i;
    logic [NUM_DIGITS-1:0]   dp_i;
    logic [NUM_DIGITS-1:0]   blank_i;
    logic [NUM_DIGITS-1:0]   blink_mask_i;
    logic [PWM_BITS-1:0]     bright_i;
    logic [7:0]              seg_o;
    logic [NUM_DIGITS-1:0]   an_o;
    logic                    frame_o;

    // Host side: supplies display data, observes the drive pins.
    modport master (
        output digits_i, dp_i, blank_i, blink_mask_i, bright_i,
        input  seg_o, an_o, frame_o
    );

    // Controller side.
    modport slave (
        input  digits_i, dp_i, blank_i, blink_mask_i, bright_i,
        output seg_o, an_o, frame_o
    );
endinterface

// File: rtl/seg7_hex_dec.sv
// Combinational hex nibble to active-high seven-segment decoder.
module seg7_hex_dec
    import seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);
    assign seg_o = HEX7SEG[hex_i];
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with per-frame shadowing,
// dead-time blanking, PWM brightness and blink.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 65536,
    parameter int BLINK_FRAMES = 48,
    parameter int PWM_BITS     = 4,
    parameter int DEAD_CYC     = 4,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic            clk,
    input  logic            rst,
    seg_scan_ctrl_if.slave  bus
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(NUM_DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_FRAMES - 1);
    localparam logic [SW-1:0] DEAD      = SW'(DEAD_CYC);

    localparam logic [7:0]            SEG_POL = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] AN_POL  = (ACTIVE_LOW != 0) ? '1 : '0;

    // Scan / blink state
    logic [SW-1:0] slot_cnt_q, slot_cnt_d;
    logic [DW-1:0] dig_idx_q,  dig_idx_d;
    logic [FW-1:0] frm_cnt_q,  frm_cnt_d;
    logic          blink_ph_q, blink_ph_d;

    // Per-frame shadow copies of the display data
    logic [4*NUM_DIGITS-1:0] dig_sh_q,   dig_sh_d;
    logic [NUM_DIGITS-1:0]   dp_sh_q,    dp_sh_d;
    logic [NUM_DIGITS-1:0]   blank_sh_q, blank_sh_d;
    logic [NUM_DIGITS-1:0]   blink_sh_q, blink_sh_d;

    // Output registers (already polarity-adjusted)
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q,  an_d;
    logic                  frame_q, frame_d;

    logic       slot_last, dig_last, wrap;
    logic [3:0] nib;
    logic [6:0] seg7;
    logic       pwm_on, lit;

    assign slot_last = (slot_cnt_q == SLOT_LAST);
    assign dig_last  = (dig_idx_q == DIG_LAST);
    assign wrap      = slot_last && dig_last;

    assign nib = dig_sh_q[{dig_idx_q, 2'b00} +: 4];

    seg7_hex_dec u_dec (
        .hex_i (nib),
        .seg_o (seg7)
    );

    // Counter and shadow next-state; shadows reload on the edge that returns the scan to digit 0.
    always_comb begin
        slot_cnt_d = slot_last ? '0 : slot_cnt_q + 1'b1;
        dig_idx_d  = dig_idx_q;
        frm_cnt_d  = frm_cnt_q;
        blink_ph_d = blink_ph_q;
        dig_sh_d   = dig_sh_q;
        dp_sh_d    = dp_sh_q;
        blank_sh_d = blank_sh_q;
        blink_sh_d = blink_sh_q;
        if (slot_last) begin
            dig_idx_d = dig_last ? '0 : dig_idx_q + 1'b1;
        end
        if (wrap) begin
            frm_cnt_d  = (frm_cnt_q == FRM_LAST) ? '0 : frm_cnt_q + 1'b1;
            blink_ph_d = (frm_cnt_q == FRM_LAST) ? ~blink_ph_q : blink_ph_q;
            dig_sh_d   = bus.digits_i;
            dp_sh_d    = bus.dp_i;
            blank_sh_d = bus.blank_i;
            blink_sh_d = bus.blink_mask_i;
        end
    end

    // Lit decision for the current slot. Brightness is used live rather
    // than shadowed, so a dimming change lands within one cycle and a
    // fresh reset (shadows all zero) still shows "0" at full brightness.
    always_comb begin
        pwm_on  = (bus.bright_i == '1) || (slot_cnt_q[SW-1 -: PWM_BITS] < bus.bright_i);
        lit     = (slot_cnt_q >= DEAD) && pwm_on && !blank_sh_q[dig_idx_q]
                  && !(blink_sh_q[dig_idx_q] && blink_ph_q);
        seg_d   = SEG_OFF ^ SEG_POL;
        an_d    = AN_OFF[NUM_DIGITS-1:0] ^ AN_POL;
        frame_d = wrap;
        if (lit) begin
            seg_d            = {dp_sh_q[dig_idx_q], seg7} ^ SEG_POL;
            an_d             = AN_POL;
            an_d[dig_idx_q]  = ~AN_POL[0];
        end
    end

    // Scan counters, blink phase and shadow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_q <= '0;
            dig_idx_q  <= '0;
            frm_cnt_q  <= '0;
            blink_ph_q <= 1'b0;
            dig_sh_q   <= '0;
            dp_sh_q    <= '0;
            blank_sh_q <= '0;
            blink_sh_q <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            dig_idx_q  <= dig_idx_d;
            frm_cnt_q  <= frm_cnt_d;
            blink_ph_q <= blink_ph_d;
            dig_sh_q   <= dig_sh_d;
            dp_sh_q    <= dp_sh_d;
            blank_sh_q <= blank_sh_d;
            blink_sh_q <= blink_sh_d;
        end
    end

    // Output registers: one cycle behind the counters, dark during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q   <= SEG_OFF ^ SEG_POL;
            an_q    <= AN_OFF[NUM_DIGITS-1:0] ^ AN_POL;
            frame_q <= 1'b0;
        end else begin
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign bus.seg_o   = seg_q;
    assign bus.an_o    = an_q;
    assign bus.frame_o = frame_q;

endmodule
